// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, reset PC and fetch-queue entry type
package cpu_pkg;
    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int PC_STEP = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch queue memory-read and decode-side bundle
interface fetch_queue_if #(
    parameter int WORD_W = cpu_pkg::WORD_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-2:0] mem_raddr;
    logic [WORD_W-1:0] mem_rdata;
    logic              dec_valid;
    logic [WORD_W-1:0] dec_instr;
    logic [ADDR_W-1:0] dec_pc;
    logic              dec_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  count;

    modport master (
        output mem_raddr, dec_valid, dec_instr, dec_pc, count,
        input  mem_rdata, dec_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_raddr, dec_valid, dec_instr, dec_pc, count,
        output mem_rdata, dec_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - DEPTH-entry register array, one write and one read port
module fq_storage #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC register, instruction read issue and decode-side queue
module fetch_queue #(
    parameter int WORD_W  = cpu_pkg::WORD_W,
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
    parameter int PC_STEP = cpu_pkg::PC_STEP
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [OCC_W-1:0]  occupancy;
    logic              pop, push, issue;
    entry_t            wr_entry, rd_entry;

    always_comb begin
        pop       = (count_q != '0) && bus.dec_ready && !bus.redirect;
        push      = inflight_q && !bus.redirect;
        // Slots already promised: queued entries plus the read in flight, less the one leaving now
        occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue     = !bus.redirect && (occupancy < OCC_W'(DEPTH));

        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (bus.redirect) begin
            pc_d     = bus.redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (issue) begin
                pc_d          = pc_q + ADDR_W'(PC_STEP);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    assign wr_entry.pc    = inflight_pc_q;
    assign wr_entry.instr = bus.mem_rdata;

    fq_storage #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(entry_t))
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign bus.mem_raddr = pc_q[ADDR_W-1:1];
    assign bus.dec_valid = (count_q != '0);
    assign bus.dec_instr = rd_entry.instr;
    assign bus.dec_pc    = rd_entry.pc;
    assign bus.count     = count_q;

    // The issue throttle must make this unreachable
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == CNT_W'(DEPTH))));
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fetch_queue_if #(.WORD_W(16), .ADDR_W(16), .DEPTH(4)) bus_a ();
    fetch_queue_if #(.WORD_W(16), .ADDR_W(16), .DEPTH(4)) bus_b ();

    fetch_queue #(.WORD_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000), .PC_STEP(2))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    fetch_queue #(.WORD_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'hFFFE), .PC_STEP(2))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word address w holds 16'h8000 + (w+1)*16'h11 (so 8011, 8022, 8033 at 0, 2, 4)
    function automatic logic [15:0] mem_word(input logic [14:0] waddr);
        logic [15:0] w;
        w = {1'b0, waddr};
        return 16'h8000 + (w + 16'd1) * 16'h0011;
    endfunction

    always @(posedge clk) begin
        bus_a.mem_rdata <= mem_word(bus_a.mem_raddr);
        bus_b.mem_rdata <= mem_word(bus_b.mem_raddr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head_a(input string tag, input logic [15:0] pc);
        check({tag, "_valid"}, 32'(bus_a.dec_valid), 32'd1);
        check({tag, "_pc"}, 32'(bus_a.dec_pc), 32'(pc));
        check({tag, "_instr"}, 32'(bus_a.dec_instr), 32'(mem_word(pc[15:1])));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_a.dec_ready   = 1'b1;
        bus_a.redirect    = 1'b0;
        bus_a.redirect_pc = 16'h0000;
        bus_b.dec_ready   = 1'b1;
        bus_b.redirect    = 1'b0;
        bus_b.redirect_pc = 16'h0000;

        // Basic fill with decode always ready, plus the wrapping instance
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(bus_a.dec_valid), 32'd0);
        check("rst_count", 32'(bus_a.count), 32'd0);
        check("rst_raddr", 32'(bus_a.mem_raddr), 32'h0);
        check("wrap_rst_raddr", 32'(bus_b.mem_raddr), 32'h7FFF);
        tick();
        check("fill_c1_valid", 32'(bus_a.dec_valid), 32'd0);
        check("fill_c1_raddr", 32'(bus_a.mem_raddr), 32'h1);
        tick();
        check_head_a("fill_h0", 16'h0000);
        check("fill_h0_instr_lit", 32'(bus_a.dec_instr), 32'h8011);
        check("wrap_h0_pc", 32'(bus_b.dec_pc), 32'hFFFE);
        check("wrap_h0_valid", 32'(bus_b.dec_valid), 32'd1);
        tick();
        check_head_a("fill_h1", 16'h0002);
        check("fill_h1_instr_lit", 32'(bus_a.dec_instr), 32'h8022);
        check("wrap_h1_pc", 32'(bus_b.dec_pc), 32'h0000);
        tick();
        check_head_a("fill_h2", 16'h0004);
        check("fill_h2_instr_lit", 32'(bus_a.dec_instr), 32'h8033);
        check("fill_h2_count", 32'(bus_a.count), 32'd1);
        check("wrap_h2_pc", 32'(bus_b.dec_pc), 32'h0002);
        check("wrap_h2_instr", 32'(bus_b.dec_instr), 32'(mem_word(15'h0001)));

        // Backpressure: decode stalled from the first cycle
        rst = 1'b1;
        bus_a.dec_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("bp_count_sat", 32'(bus_a.count), 32'd4);
        check("bp_pc_hold", 32'(bus_a.mem_raddr), 32'h4);
        tick();
        check("bp_count_sat2", 32'(bus_a.count), 32'd4);
        check("bp_pc_hold2", 32'(bus_a.mem_raddr), 32'h4);
        bus_a.dec_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check_head_a($sformatf("bp_drain%0d", i), 16'(2 * i));
            tick();
        end

        // Redirect with three queued, one in flight, and decode accepting the head
        rst = 1'b1;
        bus_a.dec_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("redir_pre_count", 32'(bus_a.count), 32'd3);
        check("redir_pre_valid", 32'(bus_a.dec_valid), 32'd1);
        bus_a.redirect    = 1'b1;
        bus_a.redirect_pc = 16'h0040;
        bus_a.dec_ready   = 1'b1;
        tick();
        bus_a.redirect = 1'b0;
        check("redir_t1_count", 32'(bus_a.count), 32'd0);
        check("redir_t1_valid", 32'(bus_a.dec_valid), 32'd0);
        check("redir_t1_raddr", 32'(bus_a.mem_raddr), 32'h20);
        tick();
        check("redir_t2_valid", 32'(bus_a.dec_valid), 32'd0);
        check("redir_t2_count", 32'(bus_a.count), 32'd0);
        tick();
        check_head_a("redir_t3", 16'h0040);
        tick();
        check_head_a("redir_t4", 16'h0042);
        tick();
        check_head_a("redir_t5", 16'h0044);

        // Reset wins over a pending redirect with the queue full
        bus_a.dec_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("rr_full_count", 32'(bus_a.count), 32'd4);
        rst = 1'b1;
        bus_a.redirect    = 1'b1;
        bus_a.redirect_pc = 16'h0080;
        tick();
        check("rr_count", 32'(bus_a.count), 32'd0);
        check("rr_valid", 32'(bus_a.dec_valid), 32'd0);
        check("rr_raddr", 32'(bus_a.mem_raddr), 32'h0);
        rst = 1'b0;
        bus_a.redirect  = 1'b0;
        bus_a.dec_ready = 1'b1;
        tick();
        check("rr_c1_valid", 32'(bus_a.dec_valid), 32'd0);
        tick();
        check_head_a("rr_h0", 16'h0000);
        tick();
        check_head_a("rr_h1", 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
